fsm_symbol_decoder: RTL and testbench



---
 rtl/fsm_symbol_decoder.sv | 132 +++++++++++++
 tb/tb_fsm_symbol_decoder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_symbol_decoder.sv
// rtl/fsm_symbol_decoder.sv - receive decoder for 3-cycle start/data/guard serial symbols
//
// Acquires symbol alignment from a 0-to-1 edge on din, recovers one data bit
// per symbol (1,b,0), packs bits MSB-first into WORD_W-bit words and presents
// them on a valid/ready handshake. Framing violations drop alignment, discard
// the partial word and bump a saturating error counter.
//
// Ports:
//   clk         rising-edge clock, din sampled every edge
//   rst_n       asynchronous active-low reset
//   din         serial line from the encoder
//   sym_bit     last decoded bit, meaningful while sym_valid=1
//   sym_valid   one-cycle pulse per good symbol
//   data_out    assembled word, first received bit in the MSB
//   data_valid  high while data_out holds an unconsumed word
//   data_ready  consumer accept
//   locked      high while symbol alignment is held
//   frame_err   one-cycle pulse per framing violation
//   overrun     one-cycle pulse when a completed word is dropped
//   err_count   saturating framing error count
module fsm_symbol_decoder #(
  parameter int WORD_W = 8,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  output logic              sym_bit,
  output logic              sym_valid,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              locked,
  output logic              frame_err,
  output logic              overrun,
  output logic [ERR_W-1:0]  err_count
);

  localparam int CNT_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    DATA  = 2'd1,
    GUARD = 2'd2,
    START = 2'd3
  } state_t;

  state_t              state;
  logic                prev;
  logic                cand;
  // Holds the first WORD_W-1 bits of a word; the last bit is appended on load.
  logic [WORD_W-2:0]   shreg;
  logic [CNT_W-1:0]    cnt;

  logic                good_sym;
  logic                bad_sym;
  logic [WORD_W-1:0]   word_next;

  assign good_sym  = (state == GUARD) && !din;
  assign bad_sym   = ((state == GUARD) && din) || ((state == START) && !din);
  assign word_next = {shreg, cand};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      prev       <= 1'b1;   // stuck-high line must not look like a rising edge
      cand       <= 1'b0;
      shreg      <= '0;
      cnt        <= '0;
      sym_bit    <= 1'b0;
      sym_valid  <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      locked     <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      err_count  <= '0;
    end else begin
      prev      <= din;
      sym_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      // Consumption; a same-cycle load below overrides this.
      if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end

      case (state)
        HUNT:    if (din && !prev) state <= DATA;
        DATA: begin
          cand  <= din;
          state <= GUARD;
        end
        GUARD:   state <= din ? HUNT : START;
        START:   state <= din ? DATA : HUNT;
        default: state <= HUNT;
      endcase

      if (good_sym) begin
        sym_valid <= 1'b1;
        sym_bit   <= cand;
        locked    <= 1'b1;
        if (cnt == LAST_BIT) begin
          cnt   <= '0;
          shreg <= '0;
          if (!data_valid || data_ready) begin
            data_out   <= word_next;
            data_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end else begin
          cnt   <= cnt + CNT_W'(1);
          shreg <= word_next[WORD_W-2:0];
        end
      end

      if (bad_sym) begin
        frame_err <= 1'b1;
        locked    <= 1'b0;
        cnt       <= '0;
        shreg     <= '0;
        if (err_count != '1) begin
          err_count <= err_count + ERR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fsm_symbol_decoder.sv
// tb/tb_fsm_symbol_decoder.sv - scoreboard bench for fsm_symbol_decoder
module tb_fsm_symbol_decoder;

  localparam int W  = 8;
  localparam int EW = 8;
  localparam int ERR_MAX = (1 << EW) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         din = 1'b1;
  logic         data_ready = 1'b0;
  logic         sym_bit, sym_valid, data_valid, locked, frame_err, overrun;
  logic [W-1:0] data_out;
  logic [EW-1:0] err_count;

  fsm_symbol_decoder #(.WORD_W(W), .ERR_W(EW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .sym_bit    (sym_bit),
    .sym_valid  (sym_valid),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .locked     (locked),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic         exp_bits[$];
  logic [W-1:0] exp_words[$];
  int exp_err = 0, exp_ovr = 0;
  int frame_seen = 0, ovr_seen = 0, dv_cycles = 0;
  bit streaming = 0;
  int rmode = 0;
  int pend = 0;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a bit or a word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sym_valid) begin
        if (exp_bits.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL sym_unexpected: got bit %0b expected none", sym_bit);
        end else begin
          check("sym_bit", sym_bit, exp_bits.pop_front());
        end
      end
      if (data_valid && data_ready) begin
        if (exp_words.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL word_unexpected: got %0h expected none", data_out);
        end else begin
          check("data_out", data_out, exp_words.pop_front());
        end
      end
      if (frame_err)  frame_seen++;
      if (overrun)    ovr_seen++;
      if (data_valid) dv_cycles++;
    end
  end

  // Consumer: 0 = never ready, 1 = always ready, 2 = random with a bounded stall.
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: data_ready = 1'b0;
      1: data_ready = 1'b1;
      default: begin
        if (data_valid && !data_ready) pend++;
        else pend = 0;
        data_ready = (pend > 6) ? 1'b1 : 1'($urandom_range(0, 1));
      end
    endcase
  end

  task automatic send_line(input logic b);
    @(posedge clk);
    #1 din = b;
  endtask

  task automatic send_sym(input logic b);
    exp_bits.push_back(b);
    send_line(1'b1);
    send_line(b);
    send_line(1'b0);
    streaming = 1;
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit expect_out);
    for (int i = W - 1; i >= 0; i--) send_sym(w[i]);
    if (expect_out) exp_words.push_back(w);
  endtask

  // A low line where a start bit is due is itself a framing error.
  task automatic idle(input int n);
    if (streaming) exp_err++;
    streaming = 0;
    repeat (n) send_line(1'b0);
  endtask

  task automatic inject_bad();
    send_line(1'b1);
    send_line(1'b1);
    send_line(1'b1);
    exp_err++;
    streaming = 0;
  endtask

  task automatic chk_err(input string name);
    repeat (2) @(negedge clk);
    check(name, err_count, (exp_err > ERR_MAX) ? ERR_MAX : exp_err);
  endtask

  initial begin
    logic [W-1:0] w;
    int to;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_sym_valid", sym_valid, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_locked", locked, 0);
    check("rst_err_count", err_count, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Line stuck high
    repeat (20) send_line(1'b1);
    @(negedge clk);
    check("high_locked", locked, 0);
    check("high_err_count", err_count, 0);
    check("high_frames", frame_seen, 0);

    // 0xA5 with consumer always ready
    rmode = 1;
    idle(2);
    dv_cycles = 0;
    send_word(8'hA5, 1);
    @(negedge clk);
    check("a5_locked", locked, 1);
    idle(3);
    check("a5_valid_cycles", dv_cycles, 1);
    check("a5_bits_left", exp_bits.size(), 0);
    check("a5_words_left", exp_words.size(), 0);
    chk_err("a5_err_count");

    // Overrun: consumer stalled across two words
    rmode = 0;
    idle(2);
    send_word(8'h3C, 1);
    send_word(8'hFF, 0);
    exp_ovr++;
    idle(2);
    check("ovr_pulses", ovr_seen, exp_ovr);
    check("ovr_valid", data_valid, 1);
    check("ovr_hold", data_out, 8'h3C);
    rmode = 1;
    repeat (3) @(negedge clk);
    check("ovr_release", data_valid, 0);
    chk_err("ovr_err_count");

    // Framing violation after 3 good bits
    idle(2);
    for (int i = 0; i < 3; i++) send_sym(1'($urandom_range(0, 1)));
    inject_bad();
    idle(1);
    chk_err("inj_err_count");
    check("inj_locked", locked, 0);
    w = W'($urandom);
    send_word(w, 1);
    idle(2);
    chk_err("inj_recover_err");

    // Random bursts, random consumer, occasional injected violations
    rmode = 2;
    for (int b = 0; b < 10; b++) begin
      idle(1 + $urandom_range(0, 2));
      for (int k = 0; k < 1 + $urandom_range(0, 2); k++) begin
        if ($urandom_range(0, 3) == 0) begin
          for (int i = 0; i < 1 + $urandom_range(0, W - 2); i++)
            send_sym(1'($urandom_range(0, 1)));
          inject_bad();
          idle(1);
        end
        w = W'($urandom);
        send_word(w, 1);
      end
    end
    idle(2);
    chk_err("rand_err_count");
    to = 0;
    while (exp_words.size() != 0 && to < 200) begin
      @(negedge clk);
      to++;
    end
    check("rand_drained", exp_words.size(), 0);
    check("rand_overruns", ovr_seen, exp_ovr);

    // Error counter saturation
    rmode = 1;
    idle(2);
    repeat (300) begin
      send_line(1'b0);
      inject_bad();
    end
    idle(2);
    chk_err("sat_err_count");
    check("sat_locked", locked, 0);
    check("sat_frames", frame_seen, exp_err);

    // Reset mid-word with a pending output word
    rmode = 0;
    idle(2);
    w = W'($urandom);
    send_word(w, 0);
    for (int i = 0; i < 3; i++) send_sym(1'($urandom_range(0, 1)));
    send_line(1'b1);
    @(negedge clk);
    check("prerst_valid", data_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_sym_bit", sym_bit, 0);
    check("arst_sym_valid", sym_valid, 0);
    check("arst_data_out", data_out, 0);
    check("arst_data_valid", data_valid, 0);
    check("arst_locked", locked, 0);
    check("arst_frame_err", frame_err, 0);
    check("arst_overrun", overrun, 0);
    check("arst_err_count", err_count, 0);
    exp_err = 0;
    frame_seen = 0;
    streaming = 0;
    din = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rmode = 1;
    idle(2);
    w = W'($urandom);
    send_word(w, 1);
    idle(3);
    chk_err("postrst_err_count");

    to = 0;
    while ((exp_words.size() != 0 || exp_bits.size() != 0) && to < 200) begin
      @(negedge clk);
      to++;
    end
    check("final_words_left", exp_words.size(), 0);
    check("final_bits_left", exp_bits.size(), 0);
    check("final_frames", frame_seen, exp_err);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
